fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end for the multi-cycle RV32 core: owns the fetch PC and issues word reads on the APB bus.
- Buffers fetched instructions in a DEPTH-entry prefetch queue and hands {instr, pc} to the decode/execute sequencer over a valid/ready handshake.
- Supports redirect (jump/branch/trap) with queue flush and squash of the in-flight read, plus a sticky halt on bus error.

Parameters:
- XLEN, 32, data/address width.
- DEPTH, 4, prefetch queue entries; power of two, 2..16.
- RESET_PC, 32'h0, PC loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rts_n  in  1  asynchronous active-low reset.
- redir_valid  in  1  redirect request, one cycle.
- redir_pc  in  XLEN  redirect target; bits [1:0] ignored.
- halt_req  in  1  level; stops issuing new reads while high.
- inst_valid  out  1  queue head valid.
- inst_ready  in  1  consumer accepts head.
- inst_data  out  XLEN  head instruction word.
- inst_pc  out  XLEN  address of head instruction.
- fault  out  1  sticky; set on APB_err.
- fault_pc  out  XLEN  address of faulting fetch.
- apb_addr  out  XLEN  read address, word aligned.
- apb_sel  out  1  APB select.
- apb_en  out  1  APB enable.
- apb_wr  out  1  tied 0.
- apb_dsize  out  4  tied 4'b1111.
- apb_rdata  in  XLEN  read data.
- apb_ready  in  1  transfer complete.
- apb_err  in  1  transfer error, qualified with apb_ready.

Behaviour:
- Reset (rts_n low, async): fetch_pc=RESET_PC; queue empty; FSM IDLE; apb_sel=0, apb_en=0, apb_addr=0; inst_valid=0; fault=0, fault_pc=0.
- FSM IDLE -> SETUP when !fault && !halt_req && free slots > reads in flight (at most one in flight). SETUP: sel=1, en=0, addr=fetch_pc, one cycle -> ACCESS. ACCESS: sel=1, en=1; hold until apb_ready.
- On ACCESS with apb_ready && !apb_err: push {rdata, addr} unless squashed; fetch_pc+=4 (wraps mod 2^XLEN); next state SETUP if issue conditions still hold, else IDLE. Back-to-back throughput: 1 word per 2 cycles with zero wait states.
- On apb_ready && apb_err: no push; fault=1, fault_pc=apb_addr; FSM -> IDLE. No further reads until reset. Queued entries still drain.
- Redirect: queue flushed same edge; fetch_pc=redir_pc & ~3. If in SETUP or ACCESS, the transfer completes on the bus (APB cannot abort) but is marked squashed: no push, no fault, no PC increment. The next SETUP issues at redir_pc. Redirect with apb_ready on the same cycle counts as squashed.
- Redirect while fault=1: fault stays set; PC is updated, but no fetch occurs.
- Queue: circular buffer with log2(DEPTH)+1-bit pointers. Push and pop in the same cycle is legal when full (pop frees the slot; the push lands). Pop occurs on inst_valid && inst_ready. Redirect overrides a pop/push in the same cycle.
- inst_valid = !empty. inst_data and inst_pc are held stable while valid && !ready.
- halt_req does not cancel an in-flight transfer; the response is still pushed.
- A zero instruction word is passed through unmodified; the decoder treats it as illegal.

Decomposition:
- Shared package core_pkg: XLEN, APB state enum {IDLE, SETUP, ACCESS}, DSIZE_WORD = 4'b1111, RESET_PC default.
- Sub-module: fetch_queue (parametrised sync FIFO with flush; push/pop/full/empty/count).

Test Plan:
- Reset, memory words 0x00000013 at 0x0/0x4/0x8, zero-wait slave, inst_ready=1 -> inst_pc 0x0, 0x4, 0x8 in order; first inst_valid 3 cycles after reset release.
- inst_ready=0, DEPTH=4 -> exactly 4 reads (0x0..0xC), then sel stays 0; raise ready -> drains, fetch resumes at 0x10.
- Slave inserts 3 wait states -> en held 4 cycles, addr stable, exactly one push.
- redir_valid with redir_pc=0x103 during ACCESS of 0x8 -> queue empty next cycle; the 0x8 data is never presented; next apb_addr=0x100; first inst_pc=0x100.
- apb_err on the read of 0x14 -> fault=1, fault_pc=0x14; prior entries 0x0..0x10 still delivered; no further sel.
- rts_n pulsed low mid-ACCESS -> all outputs at reset values immediately; restart fetching from RESET_PC.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the RV32 core front end: bus widths, APB transfer
// states and reset defaults.
package core_pkg;

    localparam int          XLEN       = 32;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [3:0]  DSIZE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: circular buffer with one extra pointer bit that tells full
// from empty. A flush empties it and overrides any push or pop in that cycle.
module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    // A pop in the same cycle frees the slot, so a push into a full queue lands.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, reads words over APB one
// transfer at a time and queues {instr, pc} for the decode/execute sequencer.
module fetch_unit #(
    parameter int              XLEN     = core_pkg::XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(core_pkg::RESET_PC)
) (
    input  logic            clk,
    input  logic            rts_n,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_pc,
    input  logic            halt_req,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic            fault,
    output logic [XLEN-1:0] fault_pc,
    output logic [XLEN-1:0] apb_addr,
    output logic            apb_sel,
    output logic            apb_en,
    output logic            apb_wr,
    output logic [3:0]      apb_dsize,
    input  logic [XLEN-1:0] apb_rdata,
    input  logic            apb_ready,
    input  logic            apb_err
);

    import core_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    apb_state_e        state_q, state_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   fault_pc_q, fault_pc_d;
    logic              fault_q, fault_d;
    logic              squash_q, squash_d;

    logic              q_push;
    logic              q_pop;
    logic              q_full;
    logic              q_empty;
    logic [CW-1:0]     q_count;
    logic [CW-1:0]     count_next;
    logic [2*XLEN-1:0] q_rdata;
    logic              xfer_done;
    logic              squashed;
    logic              can_issue;

    assign xfer_done = (state_q == ACCESS) && apb_ready;
    // A redirect arriving with the response squashes it just like an earlier one.
    assign squashed  = squash_q || redir_valid;
    assign q_pop     = !q_empty && inst_ready;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        squash_d   = squash_q;
        q_push     = 1'b0;

        if (xfer_done) begin
            squash_d = 1'b0;
            if (!squashed) begin
                if (apb_err) begin
                    fault_d    = 1'b1;
                    fault_pc_d = addr_q;
                end else begin
                    q_push     = 1'b1;
                    fetch_pc_d = fetch_pc_q + XLEN'(4);
                end
            end
        end else if (redir_valid && state_q != IDLE) begin
            squash_d = 1'b1;
        end

        if (redir_valid) fetch_pc_d = redir_pc & ~XLEN'(3);

        // Occupancy after this edge; at most one read is ever outstanding.
        count_next = redir_valid ? '0 : q_count + CW'(q_push) - CW'(q_pop);
        can_issue  = !fault_d && !halt_req && (count_next < CW'(DEPTH));

        unique case (state_q)
            IDLE: begin
                if (can_issue) begin
                    state_d = SETUP;
                    addr_d  = fetch_pc_d;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (apb_ready) begin
                    if (can_issue) begin
                        state_d = SETUP;
                        addr_d  = fetch_pc_d;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rts_n) begin
        if (!rts_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= '0;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
            squash_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
            squash_q   <= squash_d;
        end
    end

    fetch_queue #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rts_n),
        .flush_i (redir_valid),
        .push_i  (q_push),
        .data_i  ({apb_rdata, addr_q}),
        .pop_i   (q_pop),
        .data_o  (q_rdata),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count)
    );

    logic unused_q_full;
    assign unused_q_full = q_full;

    assign inst_valid = !q_empty;
    assign inst_data  = q_rdata[2*XLEN-1:XLEN];
    assign inst_pc    = q_rdata[XLEN-1:0];
    assign fault      = fault_q;
    assign fault_pc   = fault_pc_q;
    assign apb_addr   = addr_q;
    assign apb_sel    = (state_q != IDLE);
    assign apb_en     = (state_q == ACCESS);
    assign apb_wr     = 1'b0;
    assign apb_dsize  = DSIZE_WORD;

endmodule
